// File: rtl/hex_disp_pkg.sv
// Shared constants for the hex counter display: nibble/segment widths and the
// active-low gfedcba segment table for hex digits 0-F.
package hex_disp_pkg;

   localparam int unsigned SEG_W    = 7;
   localparam int unsigned NIBBLE_W = 4;

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

   // Index = nibble value, bit 0 = seg a ... bit 6 = seg g, 0 = segment lit.
   localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
      7'b1000000,  // 0
      7'b1111001,  // 1
      7'b0100100,  // 2
      7'b0110000,  // 3
      7'b0011001,  // 4
      7'b0010010,  // 5
      7'b0000010,  // 6
      7'b1111000,  // 7
      7'b0000000,  // 8
      7'b0010000,  // 9
      7'b0001000,  // A
      7'b0000011,  // b
      7'b1000110,  // C
      7'b0100001,  // d
      7'b0000110,  // E
      7'b0001110   // F
   };

endpackage

// File: rtl/hex_seg_decoder.sv
// Combinational nibble to active-low seven-segment decoder, one per displayed digit.
module hex_seg_decoder
   import hex_disp_pkg::*;
(
   input  logic [NIBBLE_W-1:0] i_nibble,
   output logic [SEG_W-1:0]    o_seg
);

   assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/hex_counter_display.sv
// Multi-digit hex up/down counter with rate divider, parallel load and registered
// seven-segment outputs. Define HEX_COUNTER_DISPLAY_LZ_BLANK_EN for leading-zero blanking.
module hex_counter_display
   import hex_disp_pkg::*;
#(
   parameter int unsigned DIGITS   = 2,
   parameter int unsigned RATE_DIV = 50000000,
   parameter int unsigned DIV_W    = 26
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      up_down,
   input  logic                      load,
   input  logic [4*DIGITS-1:0]       load_value,
   output logic [4*DIGITS-1:0]       count,
   output logic                      tick,
   output logic                      wrap,
   output logic [SEG_W*DIGITS-1:0]   hex_seg
);

   localparam int unsigned         CNT_W      = NIBBLE_W * DIGITS;
   localparam int unsigned         SEGS_W     = SEG_W * DIGITS;
   localparam logic [DIV_W-1:0]    DIV_RELOAD = DIV_W'(RATE_DIV - 1);
   localparam logic [CNT_W-1:0]    CNT_MAX    = '1;

   logic [DIV_W-1:0]  r_div;
   logic [CNT_W-1:0]  r_count;
   logic              r_tick;
   logic              r_wrap;
   logic [SEGS_W-1:0] r_seg;

   logic              w_step;
   logic [CNT_W-1:0]  w_count_next;
   logic              w_wrap_next;
   logic [SEGS_W-1:0] w_seg_raw;
   logic [SEGS_W-1:0] w_seg_next;
   logic [SEGS_W-1:0] w_seg_rst;

   assign w_step = enable && (r_div == '0);

   always_comb begin
      w_count_next = r_count;
      w_wrap_next  = 1'b0;
      if (up_down) begin
         w_count_next = r_count + CNT_W'(1);
         w_wrap_next  = (r_count == CNT_MAX);
      end else begin
         w_count_next = r_count - CNT_W'(1);
         w_wrap_next  = (r_count == '0);
      end
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_dec
      hex_seg_decoder u_dec (
         .i_nibble (r_count[g*NIBBLE_W +: NIBBLE_W]),
         .o_seg    (w_seg_raw[g*SEG_W +: SEG_W])
      );
   end

`ifdef HEX_COUNTER_DISPLAY_LZ_BLANK_EN
   logic w_lead_seen;

   // Scan from the top digit down; digits above the first nonzero one go dark.
   always_comb begin
      w_seg_next  = w_seg_raw;
      w_lead_seen = 1'b0;
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
         w_lead_seen = w_lead_seen || (r_count[i*NIBBLE_W +: NIBBLE_W] != '0);
         if (!w_lead_seen) begin
            w_seg_next[i*SEG_W +: SEG_W] = SEG_BLANK;
         end
      end
   end

   always_comb begin
      w_seg_rst = '0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         w_seg_rst[i*SEG_W +: SEG_W] = (i == 0) ? SEG_TABLE[0] : SEG_BLANK;
      end
   end
`else
   always_comb begin
      w_seg_next = w_seg_raw;
   end

   always_comb begin
      w_seg_rst = '0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         w_seg_rst[i*SEG_W +: SEG_W] = SEG_TABLE[0];
      end
   end
`endif

   // Load beats a coincident step: the step is dropped and the divider restarts.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_count <= '0;
         r_div   <= DIV_RELOAD;
         r_tick  <= 1'b0;
         r_wrap  <= 1'b0;
         r_seg   <= w_seg_rst;
      end else begin
         r_seg  <= w_seg_next;
         r_tick <= 1'b0;
         r_wrap <= 1'b0;
         if (load) begin
            r_count <= load_value;
            r_div   <= DIV_RELOAD;
         end else if (w_step) begin
            r_count <= w_count_next;
            r_div   <= DIV_RELOAD;
            r_tick  <= 1'b1;
            r_wrap  <= w_wrap_next;
         end else if (enable) begin
            r_div <= r_div - DIV_W'(1);
         end
      end
   end

   assign count   = r_count;
   assign tick    = r_tick;
   assign wrap    = r_wrap;
   assign hex_seg = r_seg;

endmodule

// File: tb/tb_hex_counter_display.sv
// Bench for hex_counter_display: two instances (2 digits / divide-by-4, 4 digits /
// divide-by-1) driven in lockstep and compared every cycle against an arithmetic model.
module tb_hex_counter_display;

   logic        clk = 1'b0;
   logic        rst, en, ud, ld;
   logic [15:0] lv;

   logic [7:0]  cnt_a;
   logic        tick_a, wrap_a;
   logic [13:0] seg_a;
   logic [15:0] cnt_b;
   logic        tick_b, wrap_b;
   logic [27:0] seg_b;

   int n_assert = 0;
   int n_fail   = 0;

`ifdef HEX_COUNTER_DISPLAY_LZ_BLANK_EN
   localparam bit LZ = 1'b1;
`else
   localparam bit LZ = 1'b0;
`endif

   localparam logic [6:0] SEGS [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };
   localparam int DIG  [2] = '{2, 4};
   localparam int RATE [2] = '{4, 1};

   always #5 clk = ~clk;

   hex_counter_display #(.DIGITS(2), .RATE_DIV(4), .DIV_W(2)) dut_a (
      .clock      (clk),
      .reset      (rst),
      .enable     (en),
      .up_down    (ud),
      .load       (ld),
      .load_value (lv[7:0]),
      .count      (cnt_a),
      .tick       (tick_a),
      .wrap       (wrap_a),
      .hex_seg    (seg_a)
   );

   hex_counter_display #(.DIGITS(4), .RATE_DIV(1), .DIV_W(1)) dut_b (
      .clock      (clk),
      .reset      (rst),
      .enable     (en),
      .up_down    (ud),
      .load       (ld),
      .load_value (lv),
      .count      (cnt_b),
      .tick       (tick_b),
      .wrap       (wrap_b),
      .hex_seg    (seg_b)
   );

   // Model state: count value, enabled cycles since last divider restart, outputs.
   longint      m_cnt  [2];
   int          m_en   [2];
   logic        m_tick [2];
   logic        m_wrap [2];
   logic [27:0] m_seg  [2];

   function automatic logic [27:0] exp_seg(input longint c, input int dig);
      logic [27:0] s;
      s = '0;
      for (int i = 0; i < dig; i++) begin
         if (LZ && i > 0 && c < (longint'(1) << (4 * i)))
            s[i*7 +: 7] = 7'b1111111;
         else
            s[i*7 +: 7] = SEGS[int'((c >> (4 * i)) & 15)];
      end
      return s;
   endfunction

   task automatic model_edge(input int k);
      longint modv;
      modv = longint'(1) << (4 * DIG[k]);
      if (rst) begin
         m_cnt[k]  = 0;
         m_en[k]   = 0;
         m_tick[k] = 1'b0;
         m_wrap[k] = 1'b0;
         m_seg[k]  = exp_seg(0, DIG[k]);
      end else begin
         m_seg[k]  = exp_seg(m_cnt[k], DIG[k]);
         m_tick[k] = 1'b0;
         m_wrap[k] = 1'b0;
         if (ld) begin
            m_cnt[k] = longint'(lv) % modv;
            m_en[k]  = 0;
         end else if (en) begin
            m_en[k]++;
            if (m_en[k] % RATE[k] == 0) begin
               m_cnt[k]  = ud ? (m_cnt[k] + 1) % modv : (m_cnt[k] + modv - 1) % modv;
               m_tick[k] = 1'b1;
               m_wrap[k] = ud ? (m_cnt[k] == 0) : (m_cnt[k] == modv - 1);
            end
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cycle(input logic r, input logic e, input logic u, input logic l,
                        input logic [15:0] v);
      rst = r; en = e; ud = u; ld = l; lv = v;
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      check("count_a", 32'(cnt_a), 32'(m_cnt[0]));
      check("tick_a", 32'(tick_a), 32'(m_tick[0]));
      check("wrap_a", 32'(wrap_a), 32'(m_wrap[0]));
      check("seg_a", 32'(seg_a), 32'(m_seg[0][13:0]));
      check("count_b", 32'(cnt_b), 32'(m_cnt[1]));
      check("tick_b", 32'(tick_b), 32'(m_tick[1]));
      check("wrap_b", 32'(wrap_b), 32'(m_wrap[1]));
      check("seg_b", 32'(seg_b), 32'(m_seg[1]));
   endtask

   initial begin
      logic [27:0] blank_exp;
      // Reset for two cycles.
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
      check("reset_count_a", 32'(cnt_a), 32'h0);
      check("reset_seg_a_d0", 32'(seg_a[6:0]), 32'(7'b1000000));

      // Count up: dut_a steps every 4th cycle, dut_b every cycle.
      for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
      check("count_a_after_12", 32'(cnt_a), 32'h03);

      // Wrap up then wrap down on dut_a.
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 16'h00FF);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
      check("wrap_up_a", 32'(wrap_a), 32'h1);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
      check("wrap_down_a", 32'({wrap_a, cnt_a}), 32'h1FF);

      // Load in a step cycle on dut_b: load wins, no tick.
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 16'h00A5);
      check("load_prio_b", 32'({tick_b, cnt_b}), 32'h000A5);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
      check("load_next_b", 32'({tick_b, cnt_b}), 32'h100A6);

      // Enable hold, then reset mid-period and restart.
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'h0055);
      for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);

      // Blanking pattern with 0x0030 loaded while disabled.
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'h0030);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
      blank_exp = LZ ? {7'b1111111, 7'b1111111, 7'b0110000, 7'b1000000}
                     : {7'b1000000, 7'b1000000, 7'b0110000, 7'b1000000};
      check("blank_seg_b", 32'(seg_b), 32'(blank_exp));

      // Randomised traffic.
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
               ($urandom_range(0, 15) == 0), 16'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/hex_counter_display.md
Name: hex_counter_display

Overview:
- Parametrised multi-digit hexadecimal up/down counter with built-in seven-segment drivers for the DE1-SoC HEX displays.
- Counts at a rate set by an internal rate divider.
- Supports parallel load, direction control and wrap indication.
- Drives DIGITS active-low segment buses directly.
- Replaces the single-digit combinational hex decoder wherever a live counting display is needed.

Parameters:
- DIGITS, 2, number of hex digits / HEX displays driven (1..6)
- RATE_DIV, 50000000, clock cycles per count step while enabled (>=1; 1 = step every enabled cycle)
- DIV_W, 26, rate-divider counter width; must hold RATE_DIV-1

Ports:
- clock  in  1  system clock (CLOCK_50 domain)
- reset  in  1  synchronous, active-high reset
- enable  in  1  counting enable; when low, divider and count hold
- up_down  in  1  1 = count up, 0 = count down; sampled on each tick
- load  in  1  single-cycle parallel load strobe
- load_value  in  4*DIGITS  value loaded on load
- count  out  4*DIGITS  current count, registered
- tick  out  1  one-cycle pulse on each count step
- wrap  out  1  one-cycle pulse when a step crosses max->0 (up) or 0->max (down)
- hex_seg  out  7*DIGITS  active-low segments; digit i uses bits [7i+6:7i], bit 0 = seg a … bit 6 = seg g

Behaviour:
- Reset, synchronous, active-high; all values take effect the cycle after reset is sampled high:
  - count = 0, divider = RATE_DIV-1, tick = 0, wrap = 0
  - hex_seg = 7'b1000000 per digit, i.e. "0" on every digit
- Reset has priority over all other inputs. Reset asserted mid-count discards any pending tick or load in that cycle.
- Rate divider:
  - When enable = 1, the divider decrements each cycle.
  - When the divider is 0 and enable = 1, it reloads RATE_DIV-1 and an internal step fires.
  - When enable = 0, the divider holds and no step fires.
- tick: registered; it is high in the cycle after the step fires, coincident with the updated count.
- Count step: count ± 1 modulo 2^(4*DIGITS), selected by up_down.
- wrap: registered alongside tick.
  - Up: asserted when count goes all-ones -> 0.
  - Down: asserted when count goes 0 -> all-ones.
- load:
  - count <= load_value next cycle and the divider reloads RATE_DIV-1.
  - load takes priority over a coincident step: that step is dropped, tick = 0 and wrap = 0 that cycle.
  - load works regardless of enable.
- hex_seg:
  - Registered from count, so it has 1 cycle of latency after count changes (2 cycles after the load/step cycle).
  - Per-digit encoding, active-low, gfedcba:
    - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
    - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
    - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
    - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- Changing up_down between ticks takes effect on the next step only, with no glitch on count.

Optional Feature:
- Macro: HEX_COUNTER_DISPLAY_LZ_BLANK_EN (leading-zero blanking).
- With the macro defined:
  - Every digit above the most significant nonzero digit drives 7'b1111111 (blank).
  - Digit 0 is never blanked.
  - After reset, hex_seg shows only digit 0 as "0"; all other digits are blank.
  - Blanking is computed in the same registered stage, so latency is unchanged.
- Without the macro: all digits are always displayed, including leading zeros.

Decomposition:
- Shared package hex_disp_pkg holds:
  - the 16-entry active-low segment constant table
  - SEG_BLANK = 7'b1111111
  - SEG_W = 7 and NIBBLE_W = 4
- One sub-module, hex_seg_decoder: combinational 4-bit nibble -> 7-bit active-low segments, instantiated DIGITS times via generate.
- The rate divider stays inline.

Test Plan:
- Reset check: DIGITS=2, assert reset 2 cycles -> count=0x00, tick=0, wrap=0, each hex_seg digit = 1000000.
- Counting: RATE_DIV=4, enable=1, up_down=1 -> tick every 4th cycle, count 0x00->0x01->0x02; hex_seg digit0 = 1111001 one cycle after count=0x01.
- Wrap both ways:
  - Load 0xFF, up -> next tick count=0x00, wrap=1 for exactly one cycle.
  - Then down -> count=0xFF, wrap=1.
- Load priority: RATE_DIV=1, enable=1, load=1 with load_value=0xA5 in the step cycle -> count=0xA5, tick=0; the next tick occurs one full period later and gives count=0xA6.
- Enable hold and reset: drop enable for 10 cycles -> count and divider frozen, no tick; then reset mid-period -> count=0 and divider restarts the full RATE_DIV period.
- Blanking: with HEX_COUNTER_DISPLAY_LZ_BLANK_EN and DIGITS=4, load 0x0030:
  - digits 3 and 2 = 1111111, digit 1 = 0110000, digit 0 = 1000000.
  - Without the macro, digits 3 and 2 = 1000000.
